// File: rtl/tlc_pkg.sv
// tlc_pkg: shared lamp/phase encodings and the phase-to-duration map for the tlc sequencer.
package tlc_pkg;
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;
  typedef enum logic [2:0] {
    ALLRED_B  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_A  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;
  function automatic int unsigned phase_dur(phase_t p, int unsigned g, int unsigned y,
                                            int unsigned a, int unsigned w);
    return (p == NS_GREEN || p == EW_GREEN) ? g :
           (p == NS_YELLOW || p == EW_YELLOW) ? y :
           (p == PED_WALK) ? w : a;
  endfunction
endpackage

// File: rtl/tlc_sequencer.sv
// tlc_sequencer: traffic light phase FSM that drives the timer load/enable handshake.
//   clk, rst (sync active-low), tick (observation only), timer_out[N] (timer count),
//   ped_req (walk button) -> timer_load, timer_en, timer_init[N], ns_light, ew_light,
//   walk, phase. Optional pedestrian walk phase enabled by macro TLC_PED_EN.
module tlc_sequencer import tlc_pkg::*; #(
  parameter int unsigned N        = 4,
  parameter int unsigned GREEN_T  = 7,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned PED_T    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [N-1:0] timer_out,
  input  logic         ped_req,
  output logic         timer_load,
  output logic         timer_en,
  output logic [N-1:0] timer_init,
  output logic [1:0]   ns_light,
  output logic [1:0]   ew_light,
  output logic         walk,
  output logic [2:0]   phase
);
  if (GREEN_T < 1 || GREEN_T >= (1 << N) || YELLOW_T < 1 || YELLOW_T >= (1 << N) ||
      ALLRED_T < 1 || ALLRED_T >= (1 << N) || PED_T < 1 || PED_T >= (1 << N)) begin : g_bad_dur
    $error("tlc_sequencer: every duration must be in 1..2^N-1");
  end
  phase_t phase_q, phase_d, grn_b, grn_a, ped_exit;
  logic ld_pend_q, run_q, adv;
  // run_q keeps load/en low for the reset-release cycle; the load is issued one cycle later.
  assign timer_load = run_q & ld_pend_q;
  assign timer_en   = run_q & ~ld_pend_q;
  // The stale count is ignored while the load is pending.
  assign adv        = run_q & ~ld_pend_q & (timer_out == '0);
  assign timer_init = N'(phase_dur(phase_q, GREEN_T, YELLOW_T, ALLRED_T, PED_T));
  assign phase      = phase_q;
`ifdef TLC_PED_EN
  logic ped_pending_q, next_dir_q;
  assign grn_b    = ped_pending_q ? PED_WALK : NS_GREEN;
  assign grn_a    = ped_pending_q ? PED_WALK : EW_GREEN;
  assign ped_exit = next_dir_q ? EW_GREEN : NS_GREEN;
  assign walk     = phase_q == PED_WALK;
`else
  assign grn_b    = NS_GREEN;
  assign grn_a    = EW_GREEN;
  assign ped_exit = ALLRED_B;
  assign walk     = 1'b0;
`endif
  always_comb begin
    phase_d  = phase_q == ALLRED_B  ? grn_b :
               phase_q == NS_GREEN  ? NS_YELLOW :
               phase_q == NS_YELLOW ? ALLRED_A :
               phase_q == ALLRED_A  ? grn_a :
               phase_q == EW_GREEN  ? EW_YELLOW :
               phase_q == PED_WALK  ? ped_exit : ALLRED_B;
    ns_light = phase_q == NS_GREEN ? GREEN : phase_q == NS_YELLOW ? YELLOW : RED;
    ew_light = phase_q == EW_GREEN ? GREEN : phase_q == EW_YELLOW ? YELLOW : RED;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      phase_q   <= ALLRED_B;
      ld_pend_q <= 1'b1;
      run_q     <= 1'b0;
`ifdef TLC_PED_EN
      ped_pending_q <= 1'b0;
      next_dir_q    <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (run_q && ld_pend_q) ld_pend_q <= 1'b0;
      else if (adv) begin
        phase_q   <= phase_d;
        ld_pend_q <= 1'b1;
      end
`ifdef TLC_PED_EN
      // Requests arriving on walk entry or during the walk are dropped.
      if (adv && phase_d == PED_WALK) begin
        ped_pending_q <= 1'b0;
        next_dir_q    <= phase_q == ALLRED_A;
      end else if (ped_req && phase_q != PED_WALK) ped_pending_q <= 1'b1;
`endif
    end
endmodule
